leitor_exibicao: RTL and testbench

Read-side controller for the result display memory. On each debounced press of the board's "next" button, it fetches the next stored ALU result through a synchronous read port and latches it for display. It presents the result as eight active-low seven-segment hex digits and wraps back to word 0 after the last valid entry. It sits between the capture buffer and the board's HEX displays, replacing direct button-clocked reads with a single-clock, debounced, handshaked read.

---
 rtl/exibicao_pkg.sv | 39 +++
 rtl/debounce_botao.sv | 49 ++++
 rtl/leitor_exibicao.sv | 119 +++++++++++
 tb/tb_leitor_exibicao.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/exibicao_pkg.sv
// Shared types and seven-segment encoding for the result display reader.
package exibicao_pkg;

    localparam int unsigned PROF_PADRAO = 25;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        LE     = 2'd1,
        ESPERA = 2'd2
    } estado_t;

    // Active-low segments {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
    localparam logic [15:0][6:0] SEG7 = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    // All eight digits showing "0".
    localparam logic [55:0] HEX_ZERO = {8{7'b1000000}};

    function automatic logic [6:0] hex7(input logic [3:0] nibble);
        return SEG7[nibble];
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and
// rising-edge pulse of the debounced level.
//   Clk, Reset : clock and synchronous active-high reset
//   botao      : raw asynchronous button, active-high
//   pressao    : one-cycle pulse when the debounced level goes 0->1
module debounce_botao #(
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic botao,
    output logic pressao
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic          sinc0;
    logic          sinc1;
    logic          estavel;
    logic [CW-1:0] cnt;

    // The counter runs only while the synchronized sample differs from the
    // stable level; any agreeing sample restarts the count.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sinc0   <= 1'b0;
            sinc1   <= 1'b0;
            estavel <= 1'b0;
            cnt     <= '0;
            pressao <= 1'b0;
        end else begin
            sinc0   <= botao;
            sinc1   <= sinc0;
            pressao <= 1'b0;
            if (sinc1 != estavel) begin
                if (cnt == CW'(DEBOUNCE - 1)) begin
                    estavel <= sinc1;
                    cnt     <= '0;
                    pressao <= sinc1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/leitor_exibicao.sv
// Read-side controller for the result display memory: each debounced press
// fetches the next stored word, latches it and shows it on eight HEX digits.
//   Clk, Reset  : clock and synchronous active-high reset
//   proximo     : raw "next" pushbutton
//   qtd_valida  : number of valid words (clamped to PROF)
//   rd_en/rd_addr/rd_dado : synchronous read port, data one cycle after rd_en
//   valor/indice/valido   : displayed word, its address, and "shown once" flag
//   hex         : eight active-low seven-segment digits of valor
module leitor_exibicao
    import exibicao_pkg::*;
#(
    parameter int unsigned PROF     = PROF_PADRAO,
    parameter int unsigned DEBOUNCE = 16
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      proximo,
    input  logic [$clog2(PROF):0]     qtd_valida,
    output logic                      rd_en,
    output logic [$clog2(PROF)-1:0]   rd_addr,
    input  logic [31:0]               rd_dado,
    output logic [31:0]               valor,
    output logic [$clog2(PROF)-1:0]   indice,
    output logic                      valido,
    output logic [55:0]               hex
);

    localparam int unsigned AW = $clog2(PROF);
    localparam int unsigned QW = AW + 1;

    estado_t       estado;
    estado_t       prox_estado;
    logic          pressao;
    logic [AW-1:0] ptr;
    logic [QW-1:0] qclamp_c;
    logic [AW-1:0] ptr_ef_c;
    logic [AW-1:0] ptr_prox_c;
    logic [55:0]   hex_c;
    logic          lanca_c;
    logic          captura_c;

    debounce_botao #(
        .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
        .Clk    (Clk),
        .Reset  (Reset),
        .botao  (proximo),
        .pressao(pressao)
    );

    // Clamp the valid count; a pointer left beyond a shrunken count restarts at 0.
    always_comb begin
        qclamp_c   = (qtd_valida > QW'(PROF)) ? QW'(PROF) : qtd_valida;
        ptr_ef_c   = (QW'(ptr) >= qclamp_c) ? '0 : ptr;
        ptr_prox_c = ((QW'(rd_addr) + QW'(1)) >= qclamp_c) ? '0 : (rd_addr + AW'(1));
    end

    // Encoded image of the word arriving from the buffer.
    for (genvar k = 0; k < 8; k++) begin : g_dig
        assign hex_c[7*k +: 7] = hex7(rd_dado[4*k +: 4]);
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox_estado;
        end
    end

    // Next-state logic; presses outside OCIOSO are dropped.
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:  if (pressao && (qclamp_c != '0)) prox_estado = LE;
            LE:      prox_estado = ESPERA;
            ESPERA:  prox_estado = OCIOSO;
            default: prox_estado = OCIOSO;
        endcase
    end

    // Output decode: launch a read on the way into LE, capture in ESPERA.
    always_comb begin
        lanca_c   = 1'b0;
        captura_c = 1'b0;
        case (estado)
            OCIOSO:  lanca_c   = pressao && (qclamp_c != '0);
            ESPERA:  captura_c = 1'b1;
            default: ;
        endcase
    end

    // Output and pointer registers; reset during ESPERA drops the arriving word.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr     <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            valor   <= '0;
            indice  <= '0;
            valido  <= 1'b0;
            hex     <= HEX_ZERO;
        end else begin
            rd_en <= lanca_c;
            if (lanca_c) begin
                rd_addr <= ptr_ef_c;
            end
            if (captura_c) begin
                valor  <= rd_dado;
                indice <= rd_addr;
                valido <= 1'b1;
                hex    <= hex_c;
                ptr    <= ptr_prox_c;
            end
        end
    end

endmodule

// File: tb/tb_leitor_exibicao.sv
module tb_leitor_exibicao;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        proximo;
    logic [5:0]  qtd_valida;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_dado;
    logic [31:0] valor;
    logic [4:0]  indice;
    logic        valido;
    logic [55:0] hex;

    logic [31:0] mem [0:31];

    int checks = 0;
    int errors = 0;
    int n_rd   = 0;
    int dbl    = 0;
    logic rd_en_ant = 1'b0;

    localparam logic [55:0] HEX0 = {8{7'b1000000}};

    leitor_exibicao #(.PROF(25), .DEBOUNCE(16)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .proximo   (proximo),
        .qtd_valida(qtd_valida),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_dado   (rd_dado),
        .valor     (valor),
        .indice    (indice),
        .valido    (valido),
        .hex       (hex)
    );

    always #5 Clk = ~Clk;

    // Buffer model: data one cycle after the read strobe.
    always @(posedge Clk) begin
        if (rd_en) rd_dado <= mem[rd_addr];
    end

    // Count read strobes and back-to-back strobes.
    always @(negedge Clk) begin
        if (rd_en) n_rd = n_rd + 1;
        if (rd_en && rd_en_ant) dbl = dbl + 1;
        rd_en_ant = rd_en;
    end

    // Hold the button until a read launches (bounded), grab outputs at E+2 and E+3, release.
    task automatic press_raw(output bit got, output logic [4:0] addr,
                             output logic [31:0] v_ant, output logic [31:0] v,
                             output logic [4:0] idx, output logic vld,
                             output logic [55:0] h);
        got = 1'b0; addr = '0; v_ant = '0; v = '0; idx = '0; vld = 1'b0; h = '0;
        proximo = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (rd_en) begin
                got  = 1'b1;
                addr = rd_addr;
                break;
            end
        end
        if (got) begin
            @(posedge Clk); #1;
            v_ant = valor;
            @(posedge Clk); #1;
            v   = valor;
            idx = indice;
            vld = valido;
            h   = hex;
        end
        proximo = 1'b0;
        repeat (30) @(posedge Clk);
    endtask

    task automatic test_reset();
        Reset = 1'b1; proximo = 1'b0; qtd_valida = 6'd0;
        repeat (4) @(posedge Clk);
        #1 Reset = 1'b0;
        checks++; if (hex !== HEX0) begin errors++; $display("FAIL reset_hex got=%h exp=%h", hex, HEX0); end
        checks++; if (valor !== 32'h0) begin errors++; $display("FAIL reset_valor got=%h exp=0", valor); end
        checks++; if (valido !== 1'b0) begin errors++; $display("FAIL reset_valido got=%b exp=0", valido); end
        checks++; if (indice !== 5'd0 || rd_addr !== 5'd0) begin errors++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", indice, rd_addr); end
        repeat (40) @(posedge Clk);
        #1;
        checks++; if (n_rd !== 0) begin errors++; $display("FAIL idle_rd_en got=%0d exp=0", n_rd); end
    endtask

    task automatic test_sequencia();
        bit got; logic [4:0] a; logic [31:0] va; logic [31:0] v; logic [4:0] ix; logic vd; logic [55:0] h;
        logic [31:0] ev [4];
        logic [4:0]  ei [4];
        ev[0] = 32'h12345678; ev[1] = 32'hDEADBEEF; ev[2] = 32'h00000001; ev[3] = 32'h12345678;
        ei[0] = 5'd0; ei[1] = 5'd1; ei[2] = 5'd2; ei[3] = 5'd0;
        mem[0] = 32'h12345678; mem[1] = 32'hDEADBEEF; mem[2] = 32'h00000001;
        qtd_valida = 6'd3;
        for (int p = 0; p < 4; p++) begin
            press_raw(got, a, va, v, ix, vd, h);
            checks++; if (!got) begin errors++; $display("FAIL seq%0d_rd_en timeout", p); end
            checks++; if (a !== ei[p]) begin errors++; $display("FAIL seq%0d_addr got=%0d exp=%0d", p, a, ei[p]); end
            checks++; if (v !== ev[p]) begin errors++; $display("FAIL seq%0d_valor got=%h exp=%h", p, v, ev[p]); end
            checks++; if (ix !== ei[p]) begin errors++; $display("FAIL seq%0d_indice got=%0d exp=%0d", p, ix, ei[p]); end
            checks++; if (vd !== 1'b1) begin errors++; $display("FAIL seq%0d_valido got=%b exp=1", p, vd); end
            if (p == 0) begin
                checks++; if (h[6:0] !== 7'b0000000 || h[55:49] !== 7'b1111001) begin
                    errors++; $display("FAIL seq0_hex got=%h exp digit0=00 digit7=79", h); end
            end
            if (p == 1) begin
                checks++; if (h[6:0] !== 7'b0001110) begin errors++; $display("FAIL seq1_digit0 got=%b exp=0001110", h[6:0]); end
            end
            if (p == 2) begin
                checks++; if (h !== {{7{7'b1000000}}, 7'b1111001}) begin errors++; $display("FAIL seq2_hex got=%h", h); end
            end
        end
    endtask

    task automatic test_bouncy();
        bit got; logic [4:0] a; logic [31:0] va; logic [31:0] v; logic [4:0] ix; logic vd; logic [55:0] h;
        int n0;
        n0 = n_rd;
        proximo = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) proximo = ~proximo;
            @(posedge Clk);
        end
        press_raw(got, a, va, v, ix, vd, h);
        #1;
        checks++; if (n_rd - n0 !== 1) begin errors++; $display("FAIL bouncy_count got=%0d exp=1", n_rd - n0); end
        checks++; if (a !== 5'd1 || v !== 32'hDEADBEEF) begin errors++; $display("FAIL bouncy_read got=%0d/%h exp=1/deadbeef", a, v); end
    endtask

    task automatic test_vazio();
        bit got; logic [4:0] a; logic [31:0] va; logic [31:0] v; logic [4:0] ix; logic vd; logic [55:0] h;
        int n0;
        qtd_valida = 6'd0;
        n0 = n_rd;
        press_raw(got, a, va, v, ix, vd, h);
        checks++; if (got || n_rd !== n0) begin errors++; $display("FAIL empty_press got=%0d exp=0 reads", n_rd - n0); end
        qtd_valida = 6'd1;
        press_raw(got, a, va, v, ix, vd, h);
        checks++; if (!got || a !== 5'd0) begin errors++; $display("FAIL one_addr got=%b/%0d exp=1/0", got, a); end
        checks++; if (va !== 32'hDEADBEEF) begin errors++; $display("FAIL one_e2_valor got=%h exp=deadbeef", va); end
        checks++; if (v !== 32'h12345678) begin errors++; $display("FAIL one_e3_valor got=%h exp=12345678", v); end
    endtask

    task automatic test_clamp();
        bit got; logic [4:0] a; logic [31:0] va; logic [31:0] v; logic [4:0] ix; logic vd; logic [55:0] h;
        for (int i = 0; i < 25; i++) mem[i] = 32'h10000000 + i;
        qtd_valida = 6'd31;
        for (int p = 0; p < 26; p++) begin
            logic [4:0] ea;
            ea = (p == 25) ? 5'd0 : 5'(p);
            press_raw(got, a, va, v, ix, vd, h);
            checks++; if (!got || a !== ea) begin errors++; $display("FAIL clamp%0d_addr got=%0d exp=%0d", p, a, ea); end
            checks++; if (v !== 32'h10000000 + 32'(ea)) begin errors++; $display("FAIL clamp%0d_valor got=%h exp=%h", p, v, 32'h10000000 + 32'(ea)); end
        end
    endtask

    task automatic test_reset_espera();
        bit got; logic [4:0] a; logic [31:0] va; logic [31:0] v; logic [4:0] ix; logic vd; logic [55:0] h;
        got = 1'b0;
        proximo = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(posedge Clk); #1;
            if (rd_en) begin got = 1'b1; break; end
        end
        checks++; if (!got || rd_addr !== 5'd1) begin errors++; $display("FAIL abort_launch got=%b/%0d exp=1/1", got, rd_addr); end
        @(posedge Clk); #1;
        Reset = 1'b1; proximo = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b0;
        checks++; if (valor !== 32'h0 || valido !== 1'b0) begin errors++; $display("FAIL abort_outputs got=%h/%b exp=0/0", valor, valido); end
        checks++; if (indice !== 5'd0 || hex !== HEX0) begin errors++; $display("FAIL abort_hex got=%0d/%h exp=0/%h", indice, hex, HEX0); end
        repeat (30) @(posedge Clk);
        press_raw(got, a, va, v, ix, vd, h);
        checks++; if (!got || a !== 5'd0 || v !== 32'h10000000) begin errors++; $display("FAIL abort_next got=%0d/%h exp=0/10000000", a, v); end
    endtask

    initial begin
        test_reset();
        test_sequencia();
        test_bouncy();
        test_vazio();
        test_clamp();
        test_reset_espera();
        checks++; if (dbl !== 0) begin errors++; $display("FAIL rd_en_back_to_back got=%0d exp=0", dbl); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
